// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arbiter
// Purpose  : Round-robin drain of four source FIFOs into one shared downstream
//            FIFO, throttled by a programmable almost-full threshold.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
    parameter int DATA_W     = 6,
    parameter int DOWN_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic                  init,
    input  logic [3:0]            afull_thr_in,
    input  logic [3:0]            fifo_empty_in,
    input  logic [4*DATA_W-1:0]   fifo_data_in,
    input  logic [3:0]            down_count_in,
    output logic [3:0]            fifo_rd_out,
    output logic                  push_out,
    output logic [DATA_W-1:0]     data_out,
    output logic [1:0]            sel_out,
    output logic [1:0]            state_out,
    output logic                  idle_out,
    output logic                  err_out
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam logic [3:0] c_full_count = 4'(DOWN_DEPTH);

    state_t     state_q, state_d;
    logic [3:0] thr_q, thr_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic       pop_q, pop_d;
    logic       err_q, err_d;

    logic       any_ready;
    logic       pop_en;
    logic [4:0] occupancy;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic       gnt_found;

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= ST_RESET;
            thr_q   <= 4'd0;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            pop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            pop_q   <= pop_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        thr_d     = thr_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        err_d     = err_q | (pop_q & (down_count_in == c_full_count));
        any_ready = |(~fifo_empty_in);
        // The in-flight word (pop_q) is not yet in down_count_in, so count it here.
        occupancy = {1'b0, down_count_in} + {4'b0000, pop_q};
        pop_en    = (state_q == ST_ACTIVE) && any_ready && !init &&
                    (occupancy < {1'b0, thr_q});

        gnt_idx   = ptr_q;
        gnt_found = 1'b0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_found && !fifo_empty_in[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end

        pop_d       = pop_en;
        fifo_rd_out = 4'b0000;
        if (pop_en) begin
            ptr_d       = gnt_idx;
            sel_d       = gnt_idx;
            fifo_rd_out = 4'b0001 << gnt_idx;
        end

        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                thr_d = afull_thr_in;
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (init)           state_d = ST_INIT;
                else if (any_ready) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                     state_d = ST_INIT;
                else if (!any_ready && !pop_q) state_d = ST_IDLE;
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign push_out  = pop_q;
    assign sel_out   = sel_q;
    assign data_out  = pop_q ? fifo_data_in[sel_q*DATA_W +: DATA_W] : '0;
    assign state_out = state_q;
    assign idle_out  = (state_q == ST_IDLE);
    assign err_out   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_arbiter
// Purpose  : Self-checking bench for fifo_rr_arbiter with modelled source FIFOs
//            and an in-order scoreboard of expected downstream pushes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arbiter;

    logic        clk = 1'b0;
    logic        RESET_L = 1'b1;
    logic        init = 1'b0;
    logic [3:0]  afull_thr_in = 4'd0;
    logic [3:0]  fifo_empty_in = 4'hF;
    logic [23:0] fifo_data_in = 24'd0;
    logic [3:0]  down_count_in = 4'd0;
    logic [3:0]  fifo_rd_out;
    logic        push_out;
    logic [5:0]  data_out;
    logic [1:0]  sel_out;
    logic [1:0]  state_out;
    logic        idle_out;
    logic        err_out;

    fifo_rr_arbiter dut (
        .clk          (clk),
        .RESET_L      (RESET_L),
        .init         (init),
        .afull_thr_in (afull_thr_in),
        .fifo_empty_in(fifo_empty_in),
        .fifo_data_in (fifo_data_in),
        .down_count_in(down_count_in),
        .fifo_rd_out  (fifo_rd_out),
        .push_out     (push_out),
        .data_out     (data_out),
        .sel_out      (sel_out),
        .state_out    (state_out),
        .idle_out     (idle_out),
        .err_out      (err_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    logic [5:0] q0[$], q1[$], q2[$], q3[$];
    logic [5:0] dreg [4];
    logic [7:0] sb[$];
    int         pop_cyc[$];

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic qpop(int i, output logic [5:0] d);
        case (i)
            0:       d = q0.pop_front();
            1:       d = q1.pop_front();
            2:       d = q2.pop_front();
            default: d = q3.pop_front();
        endcase
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) fifo_empty_in[i] = (qsize(i) == 0);
        fifo_data_in = {dreg[3], dreg[2], dreg[1], dreg[0]};
    endtask

    task automatic load(int src, logic [5:0] d);
        case (src)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            2:       q2.push_back(d);
            default: q3.push_back(d);
        endcase
        refresh();
    endtask

    task automatic expect_push(int src, logic [5:0] d);
        sb.push_back({2'(src), d});
    endtask

    // Called at a falling edge with inputs settled; returns at the next falling edge.
    task automatic cycle();
        logic [3:0] rd_s;
        logic [5:0] d;
        logic [7:0] e;
        #1;
        rd_s = fifo_rd_out;
        chk("rd_onehot", int'($countones(rd_s) <= 1), 1);
        for (int i = 0; i < 4; i++) begin
            chk("pop_of_empty", int'(rd_s[i] & fifo_empty_in[i]), 0);
            if (rd_s[i]) pop_cyc.push_back(cyc_n);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < 4; i++) begin
            if (rd_s[i] && qsize(i) > 0) begin
                qpop(i, d);
                dreg[i] = d;
            end
        end
        refresh();
        @(negedge clk);
        if (push_out) begin
            if (sb.size() == 0) begin
                chk("stray_push", int'(push_out), 0);
            end else begin
                e = sb.pop_front();
                chk("push_sel", int'(sel_out), int'(e[7:6]));
                chk("push_data", int'(data_out), int'(e[5:0]));
            end
        end else begin
            chk("nopush_data", int'(data_out), 0);
        end
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        RESET_L = 1'b0;
        #1;
        chk("rst_state", int'(state_out), 0);
        chk("rst_push", int'(push_out), 0);
        chk("rst_rd", int'(fifo_rd_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_sel", int'(sel_out), 0);
        chk("rst_idle", int'(idle_out), 0);
        chk("rst_err", int'(err_out), 0);
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        for (int i = 0; i < 4; i++) dreg[i] = 6'd0;
        sb.delete();
        pop_cyc.delete();
        down_count_in = 4'd0;
        init = 1'b0;
        refresh();
        @(negedge clk);
        RESET_L = 1'b1;
        cycle();
        chk("post_rst_state", int'(state_out), 1);
    endtask

    task automatic do_init(int thr);
        init = 1'b1;
        afull_thr_in = 4'(thr);
        cycle();
        chk("init_state", int'(state_out), 1);
        init = 1'b0;
        cycle();
        chk("idle_state", int'(state_out), 2);
        chk("idle_flag", int'(idle_out), 1);
    endtask

    task automatic chk_spacing(string tag, int n, int gap);
        chk({tag, "_pops"}, pop_cyc.size(), n);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk({tag, "_gap"}, pop_cyc[i] - pop_cyc[i-1], gap);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dreg[i] = 6'd0;
        #1;
        do_reset();

        // Single-source stream from source 2
        do_init(8);
        load(2, 6'h11); load(2, 6'h22); load(2, 6'h33);
        expect_push(2, 6'h11); expect_push(2, 6'h22); expect_push(2, 6'h33);
        run(8);
        chk_spacing("stream", 3, 1);
        chk("stream_left", sb.size(), 0);
        chk("stream_idle", int'(idle_out), 1);

        // Round-robin fairness, source 1 and 3 run dry first
        do_reset();
        do_init(8);
        load(0, 6'h10); load(0, 6'h14); load(0, 6'h18);
        load(1, 6'h11); load(1, 6'h15);
        load(2, 6'h12); load(2, 6'h16); load(2, 6'h1A);
        load(3, 6'h13); load(3, 6'h17);
        expect_push(0, 6'h10); expect_push(1, 6'h11); expect_push(2, 6'h12);
        expect_push(3, 6'h13); expect_push(0, 6'h14); expect_push(1, 6'h15);
        expect_push(2, 6'h16); expect_push(3, 6'h17); expect_push(0, 6'h18);
        expect_push(2, 6'h1A);
        run(15);
        chk_spacing("rr", 10, 1);
        chk("rr_left", sb.size(), 0);

        // Backpressure: threshold 2 with one word already downstream
        do_reset();
        do_init(2);
        down_count_in = 4'd1;
        for (int i = 0; i < 4; i++) begin
            load(0, 6'(6'h20 + i));
            expect_push(0, 6'(6'h20 + i));
        end
        run(12);
        chk_spacing("bp", 4, 2);
        chk("bp_left", sb.size(), 0);

        // Threshold zero never pops
        do_reset();
        do_init(0);
        load(0, 6'h2A);
        run(6);
        chk("thr0_pops", pop_cyc.size(), 0);
        chk("thr0_state", int'(state_out), 3);

        // Overflow error is sticky until reset
        do_reset();
        do_init(8);
        load(0, 6'h31); load(0, 6'h32);
        expect_push(0, 6'h31); expect_push(0, 6'h32);
        for (int k = 0; k < 6 && !push_out; k++) cycle();
        chk("ovf_push_seen", int'(push_out), 1);
        chk("ovf_err_before", int'(err_out), 0);
        down_count_in = 4'd8;
        cycle();
        chk("ovf_err_set", int'(err_out), 1);
        down_count_in = 4'd0;
        run(4);
        chk("ovf_err_hold", int'(err_out), 1);
        chk("ovf_left", sb.size(), 0);

        // Reset asserted between edges while a transfer is in flight
        load(1, 6'h05); load(1, 6'h06); load(1, 6'h07);
        expect_push(1, 6'h05); expect_push(1, 6'h06); expect_push(1, 6'h07);
        for (int k = 0; k < 6 && !push_out; k++) cycle();
        chk("midrst_push_seen", int'(push_out), 1);
        do_reset();
        do_init(8);
        run(3);
        chk("midrst_no_push", int'(push_out), 0);

        // Reconfigure while ACTIVE with a push in flight
        do_reset();
        do_init(8);
        for (int i = 0; i < 4; i++) begin
            load(3, 6'(6'h21 + i));
            expect_push(3, 6'(6'h21 + i));
        end
        for (int k = 0; k < 6 && !push_out; k++) cycle();
        chk("cfg_push_seen", int'(push_out), 1);
        init = 1'b1;
        afull_thr_in = 4'd4;
        #1;
        chk("cfg_rd_blocked", int'(fifo_rd_out), 0);
        cycle();
        chk("cfg_state_init", int'(state_out), 1);
        chk("cfg_no_push", int'(push_out), 0);
        down_count_in = 4'd3;
        init = 1'b0;
        cycle();
        chk("cfg_state_idle", int'(state_out), 2);
        cycle();
        chk("cfg_state_active", int'(state_out), 3);
        pop_cyc.delete();
        run(10);
        chk_spacing("cfg", 3, 2);
        chk("cfg_left", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin scheduler that drains four 6-bit source FIFOs into one shared downstream FIFO of depth 8. Pops at most one word per cycle from a non-empty source and pushes it downstream one cycle later, tagged with its source index. Throttles on a programmable almost-full threshold against the downstream occupancy. Sits between the per-lane FIFO bank and the shared output FIFO.

## Interface
- DATA_W, 6, word width (fixed for this block; all widths below assume 6)
- DOWN_DEPTH, 8, downstream FIFO depth; `down_count_in` ranges 0..8

- clk  in  1  single clock, rising edge
- RESET_L  in  1  asynchronous, active-low reset
- init  in  1  threshold-load request
- afull_thr_in  in  4  almost-full threshold, legal 0..8; captured in INIT
- fifo_empty_in  in  4  per-source empty flags, bit i = source i; reflect all pops up to the previous cycle
- fifo_data_in  in  24  source read data, source i at [6i+5:6i]; valid the cycle after that source's pop
- down_count_in  in  4  downstream occupancy; registered in the downstream FIFO, so it reflects pushes up to the previous cycle
- fifo_rd_out  out  4  one-hot pop strobe to the sources
- push_out  out  1  downstream write strobe
- data_out  out  6  downstream write data; 0 when `push_out`=0
- sel_out  out  2  source index of `data_out`
- state_out  out  2  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3
- idle_out  out  1  high only in IDLE
- err_out  out  1  sticky overflow error

## Operation
- **Reset.**
  - `RESET_L`=0 forces, asynchronously: state RESET, `fifo_rd_out`=0, `push_out`=0, `sel_out`=0, `data_out`=0, `idle_out`=0, `err_out`=0.
  - Also: `thr_q`=0, `ptr_q`=3, `pop_q`=0, `sel_q`=0.
  - Reset mid-transfer drops any pending push; no push occurs after reset.
- **FSM.** `init` has priority over every other transition except reset.
  - RESET -> INIT on the first clock edge with `RESET_L`=1.
  - INIT: `thr_q` <= `afull_thr_in` on every edge. Move to IDLE when `init`=0.
  - IDLE: if `init`=1 go to INIT. Else if any `fifo_empty_in` bit is 0, go to ACTIVE.
  - ACTIVE: if `init`=1 go to INIT. Else if all sources are empty and `pop_q`=0, go to IDLE.
  - A push already scheduled completes in every state.
- **Pop enable.** `fifo_rd_out` is combinational and asserts only in ACTIVE, when all of the following hold:
  - at least one source is non-empty;
  - `init`=0;
  - `down_count_in + pop_q < thr_q` (5-bit unsigned compare).
  - `thr_q`=0 never pops.
- **Grant.**
  - Search sources starting at index `ptr_q+1` (mod 4) and grant the first non-empty one.
  - On a pop: `ptr_q` <= granted index, `sel_q` <= granted index.
  - `pop_q` <= pop enable, every cycle.
- **Push.**
  - `push_out` = `pop_q`; `sel_out` = `sel_q`.
  - `data_out` = `pop_q ? fifo_data_in[6*sel_q +: 6] : 0`.
- **Error.** `err_out` sets when `push_out`=1 while `down_count_in`=8. It holds until reset.
- **Same-source pops.** Back-to-back pops from one source are legal when it is the only non-empty source.

## Timing
- Pop at edge-cycle t gives `push_out`/`data_out` at cycle t+1. Downstream count rises at t+2.
  - `pop_q` in the enable compare covers this one in-flight word.
- Sustained throughput is 1 word/cycle while `down_count_in + 1 < thr_q`.
- Minimum latency from a source going non-empty in IDLE to its first pop is 1 cycle (IDLE->ACTIVE), then 1 cycle to push.
- `init` asserted in ACTIVE blocks new pops the same cycle. Thresholds load from the next edge.

## Test plan
- **Reset mid-operation:** pop in progress, `RESET_L` low between edges -> all outputs 0 immediately, `state_out`=0. After release: INIT, then IDLE with `init`=0, no stray push.
- **Single-source stream:** init with thr=8. Source 2 holds 0x11, 0x22, 0x33, `down_count_in`=0 -> pops on 3 consecutive cycles. Pushes one cycle later: `data_out` 0x11, 0x22, 0x33 with `sel_out`=2. Then IDLE, `idle_out`=1.
- **Round-robin fairness:** all four sources non-empty, thr=8, count=0 -> grants 0,1,2,3,0,1 on consecutive cycles. Then empty source 1 -> sequence 2,3,0,2.
- **Backpressure:** thr=2, `down_count_in` held at 1, source 0 non-empty -> pop, stall, pop, stall (alternating). With thr=0 -> no pop ever.
- **Overflow error:** force `down_count_in`=8 while `push_out`=1 -> `err_out`=1 next cycle. It remains 1 after count drops, until reset.
- **Reconfigure in ACTIVE:** `init`=1 with a pending push -> push completes, `fifo_rd_out`=0, `state_out`=1. New thr=4 takes effect after `init` drops (IDLE, then ACTIVE).
